i2c_byte_master: RTL and testbench
==================================

# i2c_byte_master

Single-byte I2C master that generates SCL and drives or releases SDA (open-drain) from the system clock. It performs one complete transaction per request: START, 7-bit address plus R/W, slave ACK check, one data byte, ACK/NACK, then STOP. It is the initiator counterpart to the team's `I2C_slave` and lets that block be exercised from RTL instead of a behavioural bench.

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk` cycles per SCL quarter-period (Q). Must be ≥ 2. One SCL bit period is 4·Q cycles.

Ports:
- `clk`, input, 1: system clock; all logic on its rising edge.
- `RESET_N`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: transaction request; accepted only when `busy`=0.
- `rw`, input, 1: 0 = write, 1 = read.
- `addr`, input, 7: slave address.
- `wdata`, input, 8: byte to write.
- `rdata`, output, 8: byte read; updated only when a read completes.
- `busy`, output, 1: transaction in progress.
- `done`, output, 1: one-cycle pulse at transaction end.
- `ack_err`, output, 1: address or write-data NACK was seen.
- `SCL`, output, 1: I2C clock, push-pull. No clock stretching.
- `SDA`, inout, 1: open-drain. Drives 0 or 'z' only; the external pull-up supplies 1.

## Operation
- Reset values: `SCL`=1, `SDA`='z', `busy`=0, `done`=0, `ack_err`=0, `rdata`=0. State is IDLE.
- Accepting a request:
  - Condition: `start`=1 and `busy`=0.
  - `addr`, `rw` and `wdata` are latched.
  - `ack_err` is cleared, `busy` goes to 1, and the FSM goes to START.
  - `start` while `busy`=1 is ignored.
- States: IDLE → START → ADDR (8 bits) → AACK → WDATA or RDATA (8 bits) → DACK → STOP → IDLE.
- START (2Q cycles):
  - Q cycles with `SCL`=1 and `SDA` released.
  - Q cycles with `SCL`=1 and `SDA`=0.
- Bit slot (used by ADDR, AACK, WDATA, RDATA, DACK): four quarters q0..q3.
  - `SCL`=0 in q0 and q1; `SCL`=1 in q2 and q3.
  - The master updates SDA at the start of q1.
  - SDA is sampled on the last cycle of q2.
- ADDR: the byte {addr, rw} is shifted out MSB first. A '1' bit means SDA is released.
- AACK: the master releases SDA.
  - Sampled 0 = ACK: continue.
  - Sampled 1 = NACK: set `ack_err`=1 and go directly to STOP.
- WDATA: `wdata` is shifted out MSB first.
- DACK after a write: SDA is released and sampled. A sampled 1 sets `ack_err`=1; STOP follows either way.
- RDATA: SDA is released and 8 bits are sampled into a shift register, MSB first.
- DACK after a read: the master releases SDA (NACK, last byte).
- STOP (3Q cycles):
  - Q cycles with `SCL`=0 and `SDA`=0.
  - Q cycles with `SCL`=1 and `SDA`=0.
  - Q cycles with `SCL`=1 and `SDA` released.
- End of transaction: on the next cycle, `done`=1 for one cycle and `busy`=0. On a successful read, `rdata` is loaded in that same cycle.
- Reset asserted mid-transaction: outputs return to their reset values immediately (asynchronous). No STOP is generated.
- `ack_err` holds its value until the next accepted request.

## Timing
- Quarter counter: $clog2(CLK_DIV) bits, wraps at CLK_DIV−1. Bit counter: 3 bits.
- Latency of a full transaction (Q = CLK_DIV):
  - `busy` rises 1 cycle after the accepting edge.
  - `done` pulses 2Q + 18·4Q + 3Q = 77Q cycles after `busy` rises. For Q=4 this is 308 cycles.
- Latency of an address NACK: `done` pulses 2Q + 9·4Q + 3Q = 41Q cycles after `busy` rises.
- SDA transitions while `SCL`=1 occur only in START and STOP.
- A new request may be accepted in the same cycle that `done` is high, because `busy` is already 0.

## Configuration
- `I2C_MASTER_LSB_FIRST_EN`:
  - Defined: the address byte {addr, rw} and the write/read data bytes are transferred LSB first. In the address byte this puts the R/W bit on the wire first. This matches the bit order used by the team's slave bench.
  - Undefined: all bytes are MSB first, per the I2C standard.
  - ACK and NACK positions and all timing are identical in both modes.

## Test plan
- Write, address ACK and data ACK:
  - Stimulus: CLK_DIV=4, addr=0x67, rw=0, wdata=0xDD; the slave model ACKs both bytes.
  - Response: address bits on SDA are 1,1,0,0,1,1,1,0; data bits are 1,1,0,1,1,1,0,1; `done` 308 cycles after `busy` rises; `ack_err`=0.
- Read:
  - Stimulus: addr=0x67, rw=1; the slave ACKs the address and drives 0xA5.
  - Response: `rdata`=0xA5 when `done` pulses; SDA released in the 9th data slot; `ack_err`=0.
- Address NACK:
  - Stimulus: no slave model responds.
  - Response: `ack_err`=1; STOP immediately after the AACK slot; `done` 164 cycles after `busy` rises; `rdata` unchanged.
- Busy and back-to-back requests:
  - Stimulus: pulse `start` in the middle of a transaction, then again in the same cycle that `done` is high.
  - Response: the first pulse is ignored; the second starts a new transaction and `busy` stays 1.
- Reset mid-transaction:
  - Stimulus: pull `RESET_N` low during bit 3 of ADDR.
  - Response: `SCL`=1, `SDA`='z', `busy`=0 with no clock-edge delay; a later `start` works normally.
- LSB-first mode:
  - Stimulus: `I2C_MASTER_LSB_FIRST_EN` defined; addr=0x67, rw=0.
  - Response: address bits on SDA are 0,1,1,1,0,0,1,1; latency is unchanged.

Source files
------------

// File: rtl/i2c_byte_master.sv
// i2c_byte_master: single-byte I2C master (START, addr+R/W, ACK, data, ACK/NACK, STOP).
// Optional macro I2C_MASTER_LSB_FIRST_EN: shift all bytes LSB first (default MSB first).
// Ports: clk, RESET_N (async, active-low); start/rw/addr/wdata request a transaction;
// rdata read byte, busy, done (1-cycle pulse), ack_err (NACK seen);
// SCL push-pull clock, SDA open-drain data (drives 0 or z).
module i2c_byte_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       RESET_N,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       SCL,
  inout  wire        SDA
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);
`ifdef I2C_MASTER_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_AACK,
    S_WDATA, S_RDATA, S_DACK, S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [1:0]      qidx_q, qidx_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      wd_q, wd_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rw_q, rw_d;
  logic            samp_q, samp_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            aerr_q, aerr_d;
  logic            scl_q, scl_d;
  logic            sdal_q, sdal_d;
  logic            qend, slot_end;

  function automatic logic [7:0] shift(
    input logic [7:0] v, input logic b);
    return LSB ? {b, v[7:1]} : {v[6:0], b};
  endfunction

  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    qidx_d   = qidx_q;
    bcnt_d   = bcnt_q;
    sh_d     = sh_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;
    rw_d     = rw_q;
    samp_d   = samp_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    aerr_d   = aerr_q;
    scl_d    = 1'b1;
    sdal_d   = 1'b0;
    qend     = (qcnt_q == QMAX);
    slot_end = qend && (qidx_q == 2'd3);

    if (state_q != S_IDLE) begin
      qcnt_d = qend ? '0 : qcnt_q + QW'(1);
      if (qend) qidx_d = qidx_q + 2'd1;
      if (qend && qidx_q == 2'd2) samp_d = SDA;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rw_d    = rw;
          wd_d    = wdata;
          sh_d    = {addr, rw};
          aerr_d  = 1'b0;
          busy_d  = 1'b1;
          qcnt_d  = '0;
          qidx_d  = 2'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (qend && qidx_q == 2'd1) begin
          qidx_d  = 2'd0;
          bcnt_d  = 3'd0;
          state_d = S_ADDR;
        end
      end
      S_ADDR, S_WDATA: begin
        if (slot_end) begin
          sh_d   = shift(sh_q, 1'b0);
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7)
            state_d = (state_q == S_ADDR) ? S_AACK : S_DACK;
        end
      end
      S_AACK: begin
        if (slot_end) begin
          bcnt_d = 3'd0;
          if (samp_q) begin
            aerr_d  = 1'b1;
            state_d = S_STOP;
          end else begin
            sh_d    = wd_q;
            state_d = rw_q ? S_RDATA : S_WDATA;
          end
        end
      end
      S_RDATA: begin
        if (slot_end) begin
          sh_d   = shift(sh_q, samp_q);
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = S_DACK;
        end
      end
      S_DACK: begin
        if (slot_end) begin
          if (!rw_q && samp_q) aerr_d = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (qend && qidx_q == 2'd2) begin
          qidx_d  = 2'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (rw_q && !aerr_q) rdata_d = sh_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pins are registered from the next state so they
    // line up with the state and stay glitch-free.
    unique case (state_d)
      S_IDLE:  ;
      S_START: sdal_d = qidx_d[0];
      S_STOP: begin
        scl_d  = (qidx_d != 2'd0);
        sdal_d = (qidx_d != 2'd2);
      end
      default: begin
        scl_d = qidx_d[1];
        // q0 keeps the previous level; new bit lands in q1
        if (qidx_d == 2'd0)
          sdal_d = sdal_q;
        else if (state_d == S_ADDR || state_d == S_WDATA)
          sdal_d = LSB ? !sh_d[0] : !sh_d[7];
      end
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      qidx_q  <= 2'd0;
      bcnt_q  <= 3'd0;
      sh_q    <= 8'd0;
      wd_q    <= 8'd0;
      rdata_q <= 8'd0;
      rw_q    <= 1'b0;
      samp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      aerr_q  <= 1'b0;
      scl_q   <= 1'b1;
      sdal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      qidx_q  <= qidx_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      samp_q  <= samp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      aerr_q  <= aerr_d;
      scl_q   <= scl_d;
      sdal_q  <= sdal_d;
    end
  end

  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = aerr_q;
  assign SCL     = scl_q;
  assign SDA     = sdal_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: bench for i2c_byte_master with a bus-level
// waveform model, a reactive slave and directed transactions.
module tb_i2c_byte_master;
  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       RESET_N = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] wdata = 8'd0;
  wire  [7:0] rdata;
  wire        busy, done, ack_err, SCL;
  wire        sda_w;
  logic       slave_low = 1'b0;

  assign sda_w = slave_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  i2c_byte_master #(.CLK_DIV(Q)) dut (
    .clk(clk), .RESET_N(RESET_N), .start(start), .rw(rw),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
    .done(done), .ack_err(ack_err), .SCL(SCL), .SDA(sda_w)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wcyc = 0;
  logic [3:0] exp_q[$];
  logic bits_q[$];

  bit s_en = 0, s_ack_a = 0, s_ack_d = 0, s_read = 0;
  logic [7:0] s_rbyte = 8'd0;
  int s_slot = 100;

`ifdef I2C_MASTER_LSB_FIRST_EN
  localparam logic [7:0] ADDR_W = 8'h73;
  localparam logic [7:0] DATA_W = 8'hBB;
`else
  localparam logic [7:0] ADDR_W = 8'hCE;
  localparam logic [7:0] DATA_W = 8'hDD;
`endif

  // j-th bit of byte b in wire order
  function automatic logic wbit(input logic [7:0] b, input int j);
`ifdef I2C_MASTER_LSB_FIRST_EN
    return b[j];
`else
    return b[7-j];
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] wire_byte(input int i0);
    logic [7:0] v = 8'd0;
    for (int i = 0; i < 8; i++)
      if (i0 + i < bits_q.size()) v = {v[6:0], bits_q[i0+i]};
      else v = {v[6:0], 1'bx};
    return v;
  endfunction

  // expected {SCL, SDA, busy, done} per cycle from first busy cycle
  task automatic push_model(input logic [6:0] a, input logic r,
      input logic [7:0] d, input bit ack_a, input bit ack_d,
      input logic [7:0] rb);
    logic [7:0] ab;
    bit mlow[18];
    bit slow[18];
    int ns;
    bit ml;
    ab = {a, r};
    ns = ack_a ? 18 : 9;
    for (int k = 0; k < 18; k++) begin
      if (k < 8) begin
        mlow[k] = !wbit(ab, k); slow[k] = 1'b0;
      end else if (k == 8) begin
        mlow[k] = 1'b0; slow[k] = ack_a;
      end else if (k < 17) begin
        mlow[k] = r ? 1'b0 : !wbit(d, k - 9);
        slow[k] = r & !wbit(rb, k - 9);
      end else begin
        mlow[k] = 1'b0; slow[k] = !r & ack_d;
      end
    end
    for (int c = 0; c < Q; c++) exp_q.push_back(4'b1110);
    for (int c = 0; c < Q; c++) exp_q.push_back(4'b1010);
    for (int k = 0; k < ns; k++)
      for (int qq = 0; qq < 4; qq++)
        for (int c = 0; c < Q; c++) begin
          if (qq == 0) ml = (k == 0) ? 1'b1 : mlow[k-1];
          else ml = mlow[k];
          exp_q.push_back({qq >= 2, !(ml | slow[k]), 2'b10});
        end
    for (int c = 0; c < Q; c++) exp_q.push_back(4'b0010);
    for (int c = 0; c < Q; c++) exp_q.push_back(4'b1010);
    for (int c = 0; c < Q; c++) exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1101);
  endtask

  // compare process + bus monitor
  initial begin
    logic [3:0] act, e;
    logic pscl = 1'b1, psda = 1'b1;
    forever begin
      @(negedge clk);
      act = {SCL, sda_w, busy, done};
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 4'b1100;
      wcyc++;
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL wave cyc=%0d got=%b want=%b", wcyc, act, e);
      end
      if (pscl && SCL && psda && !sda_w) bits_q.delete();
      else if (!pscl && SCL) bits_q.push_back(sda_w);
      pscl = SCL;
      psda = sda_w;
    end
  end

  // slave: slot k starts at the k-th SCL fall after START
  initial begin
    logic spscl = 1'b1, spsda = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (spscl && SCL && spsda && !sda_w) s_slot = -1;
      else if (spscl && !SCL) s_slot++;
      spscl = SCL;
      spsda = sda_w;
      slave_low = 1'b0;
      if (s_en) begin
        if (s_slot == 8) slave_low = s_ack_a;
        else if (s_read && s_slot >= 9 && s_slot <= 16)
          slave_low = !wbit(s_rbyte, s_slot - 9);
        else if (!s_read && s_slot == 17) slave_low = s_ack_d;
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the accept edge
  task automatic do_start(input logic [6:0] a, input logic r,
      input logic [7:0] d, input bit ack_a, input bit ack_d,
      input logic [7:0] rb, input bit en);
    s_en = en; s_ack_a = ack_a; s_ack_d = ack_d;
    s_read = r; s_rbyte = rb;
    addr = a; rw = r; wdata = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_model(a, r, d, ack_a, ack_d, rb);
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", SCL, 1);
    chk("rst_sda", sda_w, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ackerr", ack_err, 0);
    chk("rst_rdata", rdata, 0);
    RESET_N = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // write with both ACKs
    do_start(7'h67, 1'b0, 8'hDD, 1, 1, 8'h00, 1);
    wait_done(0, n);
    chk("wr_lat", n, 308);
    chk("wr_ackerr", ack_err, 0);
    chk("wr_nbits", bits_q.size(), 19);
    chk("wr_addr", wire_byte(0), ADDR_W);
    chk("wr_aack", bits_q[8], 0);
    chk("wr_data", wire_byte(9), DATA_W);
    chk("wr_dack", bits_q[17], 0);

    // read 0xA5
    repeat (3) @(posedge clk);
    #1;
    do_start(7'h67, 1'b1, 8'h00, 1, 0, 8'hA5, 1);
    wait_done(0, n);
    chk("rd_lat", n, 308);
    chk("rd_rdata", rdata, 8'hA5);
    chk("rd_ackerr", ack_err, 0);
    chk("rd_wire", wire_byte(9), 8'hA5);
    chk("rd_nack", bits_q[17], 1);

    // address NACK, no slave
    repeat (3) @(posedge clk);
    #1;
    do_start(7'h3C, 1'b1, 8'h00, 0, 0, 8'h00, 0);
    wait_done(0, n);
    chk("nk_lat", n, 164);
    chk("nk_ackerr", ack_err, 1);
    chk("nk_rdata", rdata, 8'hA5);
    chk("nk_nbits", bits_q.size(), 10);
    chk("nk_abit", bits_q[8], 1);

    // ignored start while busy, then back-to-back
    repeat (3) @(posedge clk);
    #1;
    do_start(7'h12, 1'b0, 8'h5A, 1, 1, 8'h00, 1);
    chk("acc_clr", ack_err, 0);
    repeat (100) @(posedge clk);
    #1;
    addr = 7'h7F; rw = 1'b1; wdata = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(101, n);
    chk("bz_lat", n, 308);
    chk("bz_ackerr", ack_err, 0);
    do_start(7'h55, 1'b1, 8'h00, 1, 0, 8'h3C, 1);
    chk("b2b_busy", busy, 1);
    wait_done(0, n);
    chk("b2b_lat", n, 308);
    chk("b2b_rdata", rdata, 8'h3C);

    // reset during ADDR bit 3
    repeat (3) @(posedge clk);
    #1;
    do_start(7'h2A, 1'b0, 8'h81, 1, 1, 8'h00, 1);
    repeat (62) @(posedge clk);
    #2;
    RESET_N = 1'b0;
    exp_q.delete();
    #1;
    chk("mr_scl", SCL, 1);
    chk("mr_sda", sda_w, 1);
    chk("mr_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    RESET_N = 1'b1;
    @(posedge clk);
    #1;
    do_start(7'h2A, 1'b0, 8'h81, 1, 1, 8'h00, 1);
    wait_done(0, n);
    chk("ar_lat", n, 308);
    chk("ar_ackerr", ack_err, 0);
    chk("ar_data", wire_byte(9), 8'h81);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
